// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// FSM state encoding, word/lane geometry and a byte-merge helper.
package dm_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Replace the enabled byte lanes of old_w with those of new_w.
  function automatic logic [WORD_W-1:0] be_merge(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [LANES-1:0]  be
  );
    logic [WORD_W-1:0] r;
    r = old_w;
    for (int b = 0; b < LANES; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_array.sv
// Word-organised data storage: async read, byte-enable write,
// whole array cleared asynchronously on reset.
module dm_array
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [LANES-1:0]  be_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Clear on reset, otherwise write only the enabled byte lanes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < LANES; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding load/store responder with fixed latency,
// request error checking and a committed-store write log.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wlog_valid,
  output logic [31:0]       wlog_addr,
  output logic [WORD_W-1:0] wlog_data
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [LANES-1:0]  be_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;
  logic              wlog_valid_q;
  logic [31:0]       wlog_addr_q;
  logic [WORD_W-1:0] wlog_data_q;

  logic              capture;
  logic              enter_resp;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic [LANES-1:0]  cur_be;
  logic              cur_err;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] merged;

  // With LATENCY=1 the response is formed straight from the live request.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
  end

  assign cur_err = (cur_addr[1:0] != 2'b00)
                || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS))
                || (cur_we && (cur_be == '0));

  assign merged = be_merge(mem_rdata, cur_wdata, cur_be);
  assign mem_we = enter_resp && cur_we && !cur_err;

  dm_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .addr_i  (cur_addr[AW+1:2]),
    .be_i    (cur_be),
    .wdata_i (cur_wdata),
    .rdata_o (mem_rdata)
  );

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d      = '0;
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and response/log registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      wlog_valid_q <= 1'b0;
      wlog_addr_q  <= '0;
      wlog_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wlog_valid_q <= 1'b0;
      if (capture) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (enter_resp) begin
        err_q   <= cur_err;
        rdata_q <= (cur_err || cur_we) ? '0 : mem_rdata;
        if (cur_we && !cur_err) begin
          wlog_valid_q <= 1'b1;
          wlog_addr_q  <= {cur_addr[31:2], 2'b00};
          wlog_data_q  <= merged;
        end
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign wlog_valid = wlog_valid_q;
  assign wlog_addr  = wlog_addr_q;
  assign wlog_data  = wlog_data_q;

endmodule
